// File: rtl/rf_port_if.sv
// Requester-side bundle of rf_port_ctrl: two write requesters, the port-A reader and the port-B reader.
interface rf_port_if #(
    parameter int unsigned PW = 2,
    parameter int unsigned DW = 8
);
    logic          w0_valid;
    logic [PW-1:0] w0_addr;
    logic [DW-1:0] w0_data;
    logic          w0_ready;

    logic          w1_valid;
    logic [PW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          w1_ready;

    logic          ra_valid;
    logic [PW-1:0] ra_addr;
    logic          ra_ready;
    logic [DW-1:0] ra_data;

    logic [PW-1:0] rb_addr;
    logic [DW-1:0] rb_data;

    modport master (
        output w0_valid, w0_addr, w0_data,
        input  w0_ready,
        output w1_valid, w1_addr, w1_data,
        input  w1_ready,
        output ra_valid, ra_addr,
        input  ra_ready, ra_data,
        output rb_addr,
        input  rb_data
    );

    modport slave (
        input  w0_valid, w0_addr, w0_data,
        output w0_ready,
        input  w1_valid, w1_addr, w1_data,
        output w1_ready,
        input  ra_valid, ra_addr,
        output ra_ready, ra_data,
        input  rb_addr,
        output rb_data
    );
endinterface

// File: rtl/rf_port_ctrl.sv
// Register-file port-A sharing: round-robin between two writers, streak-limited stalling of the reader.
// Optional stall counter output stall_cnt is enabled by defining RF_PERF_CNT_EN.
module rf_port_ctrl #(
    parameter int unsigned PW     = 2,
    parameter int unsigned DW     = 8,
    parameter int unsigned STREAK = 3
) (
    input  logic          clk,
    input  logic          reset,
    rf_port_if.slave      rf_bus,
    output logic          rf_wr_en,
    output logic [PW-1:0] rf_addrA,
    output logic [PW-1:0] rf_addrB,
    output logic [DW-1:0] rf_dat_in,
    input  logic [DW-1:0] rf_datA,
    input  logic [DW-1:0] rf_datB
`ifdef RF_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);
    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK);

    logic          rr_pref;
    logic          rr_pref_nxt;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    logic          force_rd_c;
    logic          gnt0_c;
    logic          gnt1_c;

    // Grant decision; nothing is granted while reset is high.
    always_comb begin
        force_rd_c = rf_bus.ra_valid && (streak == STREAK_MAX);
        gnt0_c = !reset && !force_rd_c && rf_bus.w0_valid && (!rf_bus.w1_valid || !rr_pref);
        gnt1_c = !reset && !force_rd_c && rf_bus.w1_valid && (!rf_bus.w0_valid || rr_pref);
    end

    // Port-A steering and handshakes; a read sharing the write address sees the pre-write value.
    always_comb begin
        rf_addrA  = rf_bus.ra_addr;
        rf_dat_in = rf_bus.w0_data;
        if (gnt0_c) begin
            rf_addrA = rf_bus.w0_addr;
        end else if (gnt1_c) begin
            rf_addrA  = rf_bus.w1_addr;
            rf_dat_in = rf_bus.w1_data;
        end
        rf_wr_en        = gnt0_c || gnt1_c;
        rf_bus.w0_ready = gnt0_c;
        rf_bus.w1_ready = gnt1_c;
        rf_bus.ra_ready = !reset && rf_bus.ra_valid
                          && (!rf_wr_en || (rf_bus.ra_addr == rf_addrA));
    end

    assign rf_addrB       = rf_bus.rb_addr;
    assign rf_bus.rb_data = rf_datB;
    assign rf_bus.ra_data = rf_datA;

    // Next-state: preference flips away from the last granted writer; streak counts stalled read cycles.
    always_comb begin
        rr_pref_nxt = rr_pref;
        streak_nxt  = '0;
        if (gnt0_c) begin
            rr_pref_nxt = 1'b1;
        end else if (gnt1_c) begin
            rr_pref_nxt = 1'b0;
        end
        if (rf_bus.ra_valid && !rf_bus.ra_ready) begin
            streak_nxt = (streak >= STREAK_MAX) ? STREAK_MAX : streak + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_pref <= 1'b0;
            streak  <= '0;
        end else begin
            rr_pref <= rr_pref_nxt;
            streak  <= streak_nxt;
        end
    end

`ifdef RF_PERF_CNT_EN
    logic stall_c;

    // One count per cycle in which any requester waits, however many are waiting.
    assign stall_c = (rf_bus.w0_valid && !rf_bus.w0_ready)
                  || (rf_bus.w1_valid && !rf_bus.w1_ready)
                  || (rf_bus.ra_valid && !rf_bus.ra_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rf_port_ctrl.sv
// Bench for rf_port_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rf_port_ctrl;
    localparam int unsigned PW     = 2;
    localparam int unsigned DW     = 8;
    localparam int unsigned STREAK = 3;
    localparam int unsigned NREG   = 1 << PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_init;
    logic          rf_wr_en;
    logic [PW-1:0] rf_addrA;
    logic [PW-1:0] rf_addrB;
    logic [DW-1:0] rf_dat_in;
    logic [DW-1:0] rf_datA;
    logic [DW-1:0] rf_datB;
    logic [DW-1:0] rf_mem [NREG];
`ifdef RF_PERF_CNT_EN
    logic [15:0]   stall_cnt;
    int            m_stall;
    logic [15:0]   s_stall;
`endif

    rf_port_if #(.PW(PW), .DW(DW)) bus ();

    rf_port_ctrl #(.PW(PW), .DW(DW), .STREAK(STREAK)) dut (
        .clk       (clk),
        .reset     (reset),
        .rf_bus    (bus),
        .rf_wr_en  (rf_wr_en),
        .rf_addrA  (rf_addrA),
        .rf_addrB  (rf_addrB),
        .rf_dat_in (rf_dat_in),
        .rf_datA   (rf_datA),
        .rf_datB   (rf_datB)
`ifdef RF_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Register file with write through port A and two asynchronous read ports.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(NREG); i++) rf_mem[i] <= '0;
        end else if (rf_wr_en) begin
            rf_mem[rf_addrA] <= rf_dat_in;
        end
    end
    assign rf_datA = rf_mem[rf_addrA];
    assign rf_datB = rf_mem[rf_addrB];

    int            errors = 0;
    int            checks = 0;
    int            m_pref;
    int            m_streak;
    logic [DW-1:0] m_regs [NREG];
    logic          h_w0, h_w1, h_ra;
    logic          s_w0r, s_w1r, s_rar, s_wr;
    logic [PW-1:0] s_addrA;
    logic [DW-1:0] s_ra_data, s_rb_data;
    int            ra_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample outputs after the inputs settle, compare to the model, advance the model.
    task automatic step();
        int            g;
        logic [PW-1:0] ea;
        logic [DW-1:0] ed;
        logic          er;
        #1;
        if (reset) begin
            m_pref   = 0;
            m_streak = 0;
            ra_wait  = 0;
`ifdef RF_PERF_CNT_EN
            m_stall  = 0;
`endif
        end
        s_w0r     = bus.w0_ready;
        s_w1r     = bus.w1_ready;
        s_rar     = bus.ra_ready;
        s_wr      = rf_wr_en;
        s_addrA   = rf_addrA;
        s_ra_data = bus.ra_data;
        s_rb_data = bus.rb_data;
        g = -1;
        if (!reset && !(bus.ra_valid && m_streak == int'(STREAK))) begin
            if (bus.w0_valid && bus.w1_valid) g = m_pref;
            else if (bus.w0_valid)            g = 0;
            else if (bus.w1_valid)            g = 1;
        end
        ea = (g == 0) ? bus.w0_addr : (g == 1) ? bus.w1_addr : bus.ra_addr;
        ed = (g == 1) ? bus.w1_data : bus.w0_data;
        er = !reset && bus.ra_valid && (g < 0 || bus.ra_addr == ea);

        check("w0_ready", 32'(s_w0r), 32'(g == 0));
        check("w1_ready", 32'(s_w1r), 32'(g == 1));
        check("rf_wr_en", 32'(s_wr), 32'(g >= 0));
        check("ra_ready", 32'(s_rar), 32'(er));
        check("rf_addrA", 32'(s_addrA), 32'(ea));
        check("rf_addrB", 32'(rf_addrB), 32'(bus.rb_addr));
        check("rb_data", 32'(s_rb_data), 32'(m_regs[bus.rb_addr]));
        if (g >= 0) check("rf_dat_in", 32'(rf_dat_in), 32'(ed));
        if (er)     check("ra_data", 32'(s_ra_data), 32'(m_regs[bus.ra_addr]));
`ifdef RF_PERF_CNT_EN
        s_stall = stall_cnt;
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

        // Worst-case read latency bound, measured on the DUT's own ready.
        if (!reset && bus.ra_valid) begin
            if (s_rar) begin
                check("ra_latency", 32'(ra_wait <= int'(STREAK)), 32'd1);
                ra_wait = 0;
            end else begin
                ra_wait++;
                if (ra_wait == int'(STREAK) + 1) check("ra_wait_bound", 32'(ra_wait), 32'(STREAK));
            end
        end

        h_w0 = (g == 0);
        h_w1 = (g == 1);
        h_ra = er;
        if (h_ra) ra_wait = 0;
        if (!reset) begin
            if (g >= 0) begin
                m_regs[ea] = ed;
                m_pref = (g == 0) ? 1 : 0;
            end
            if (bus.ra_valid && !er)
                m_streak = (m_streak < int'(STREAK)) ? m_streak + 1 : int'(STREAK);
            else
                m_streak = 0;
`ifdef RF_PERF_CNT_EN
            if (((bus.w0_valid && g != 0) || (bus.w1_valid && g != 1) || (bus.ra_valid && !er))
                && m_stall < 65535)
                m_stall++;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        mem_init     = 1'b1;
        bus.w0_valid = 1'b0; bus.w0_addr = '0; bus.w0_data = '0;
        bus.w1_valid = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
        bus.ra_valid = 1'b0; bus.ra_addr = '0;
        bus.rb_addr  = '0;
        m_pref = 0; m_streak = 0; ra_wait = 0;
`ifdef RF_PERF_CNT_EN
        m_stall = 0;
`endif
        for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;

        // Reset state, with a writer already requesting.
        bus.w0_valid = 1'b1;
        step();
        check("rst_w0_ready", 32'(s_w0r), 32'd0);
        check("rst_wr_en", 32'(s_wr), 32'd0);
        reset = 1'b0;
        bus.w0_valid = 1'b0;

        // Single write, visible on port B next cycle.
        bus.w0_valid = 1'b1; bus.w0_addr = 2'd2; bus.w0_data = 8'hA5;
        step();
        check("sw_w0_ready", 32'(s_w0r), 32'd1);
        check("sw_wr_en", 32'(s_wr), 32'd1);
        check("sw_addrA", 32'(s_addrA), 32'd2);
        bus.w0_valid = 1'b0;
        bus.rb_addr = 2'd2;
        step();
        check("sw_rb_data", 32'(s_rb_data), 32'hA5);

        // Both writers continuously valid: grants alternate starting with w0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.w0_valid = 1'b1; bus.w0_addr = 2'd1; bus.w0_data = 8'h11;
        bus.w1_valid = 1'b1; bus.w1_addr = 2'd3; bus.w1_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_w0", 32'(s_w0r), 32'(i % 2 == 0));
            check("alt_w1", 32'(s_w1r), 32'(i % 2 == 1));
            if (h_w0) bus.w0_data = bus.w0_data + 8'd1;
            if (h_w1) bus.w1_data = bus.w1_data + 8'd1;
        end

        // Reader on reg 0 against two busy writers: forced read on the 4th cycle, then streak restarts.
        bus.ra_valid = 1'b1; bus.ra_addr = 2'd0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                check("str_ra_ready", 32'(s_rar), 32'(i == 3));
                check("str_wr_en", 32'(s_wr), 32'(i != 3));
            end
        end
        bus.ra_valid = 1'b0;
        for (int k = 0; k < 4 && (bus.w0_valid || bus.w1_valid); k++) begin
            step();
            if (h_w0) bus.w0_valid = 1'b0;
            if (h_w1) bus.w1_valid = 1'b0;
        end
        bus.w0_valid = 1'b0;
        bus.w1_valid = 1'b0;

        // Same-address read during a write returns the old value, new value a cycle later.
        bus.w0_valid = 1'b1; bus.w0_addr = 2'd1; bus.w0_data = 8'h11;
        step();
        bus.w0_valid = 1'b0;
        bus.w1_valid = 1'b1; bus.w1_addr = 2'd1; bus.w1_data = 8'h77;
        bus.ra_valid = 1'b1; bus.ra_addr = 2'd1;
        step();
        check("same_ra_ready", 32'(s_rar), 32'd1);
        check("same_w1_ready", 32'(s_w1r), 32'd1);
        check("same_ra_old", 32'(s_ra_data), 32'h11);
        bus.w1_valid = 1'b0;
        step();
        check("same_ra_new", 32'(s_ra_data), 32'h77);
        bus.ra_valid = 1'b0;

        // Reset mid-stream: no write lands and w0 is preferred again afterwards.
        bus.w0_valid = 1'b1; bus.w0_addr = 2'd0; bus.w0_data = 8'hC3;
        step();
        bus.w0_addr = 2'd2; bus.w0_data = 8'h5A;
        reset = 1'b1;
        step();
        check("mid_rst_w0_ready", 32'(s_w0r), 32'd0);
        check("mid_rst_wr_en", 32'(s_wr), 32'd0);
        step();
        reset = 1'b0;
        bus.w0_valid = 1'b0;
        bus.rb_addr = 2'd2;
        step();
        check("mid_rst_reg_kept", 32'(s_rb_data), 32'hA5);
        bus.w0_valid = 1'b1; bus.w0_addr = 2'd0; bus.w0_data = 8'h01;
        bus.w1_valid = 1'b1; bus.w1_addr = 2'd3; bus.w1_data = 8'h02;
        step();
        check("mid_rst_pref_w0", 32'(s_w0r), 32'd1);
        check("mid_rst_pref_w1", 32'(s_w1r), 32'd0);
        bus.w0_valid = 1'b0;
        step();
        bus.w1_valid = 1'b0;

        // Random traffic obeying the hold-until-ready rule, with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            if (!bus.w0_valid && $urandom_range(0, 99) < 60) begin
                bus.w0_valid = 1'b1; bus.w0_addr = PW'($urandom); bus.w0_data = DW'($urandom);
            end
            if (!bus.w1_valid && $urandom_range(0, 99) < 60) begin
                bus.w1_valid = 1'b1; bus.w1_addr = PW'($urandom); bus.w1_data = DW'($urandom);
            end
            if (!bus.ra_valid && $urandom_range(0, 99) < 50) begin
                bus.ra_valid = 1'b1; bus.ra_addr = PW'($urandom);
            end
            bus.rb_addr = PW'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            step();
            if (h_w0) bus.w0_valid = 1'b0;
            if (h_w1) bus.w1_valid = 1'b0;
            if (h_ra) bus.ra_valid = 1'b0;
        end
        reset = 1'b0;
        bus.w0_valid = 1'b0;
        bus.w1_valid = 1'b0;
        bus.ra_valid = 1'b0;

`ifdef RF_PERF_CNT_EN
        // Three stalled-read cycles plus two stalled-write cycles count five.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.w0_valid = 1'b1; bus.w0_addr = 2'd1; bus.w0_data = 8'h01;
        bus.w1_valid = 1'b1; bus.w1_addr = 2'd3; bus.w1_data = 8'h02;
        bus.ra_valid = 1'b1; bus.ra_addr = 2'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (h_ra) bus.ra_valid = 1'b0;
            if (i >= 4) begin
                if (h_w0) bus.w0_valid = 1'b0;
                if (h_w1) bus.w1_valid = 1'b0;
            end
        end
        step();
        check("perf_stall_cnt", 32'(s_stall), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_port_ctrl.md
# rf_port_ctrl

Port controller for the 8-bit register file, which has one write path tied to read port A: the write lands at the address on port A. The block shares port A between two write requesters (ALU writeback, load return) and one port-A reader (decode), using round-robin arbitration between the writers and an anti-starvation streak counter for the reader. Port B passes straight through. The block sits between decode/writeback and the register file and owns every register-file control input.

## Interface
- PW, 2, register address width (2**PW registers)
- DW, 8, data width
- STREAK, 3, max consecutive cycles a pending port-A read may be stalled by writes (1..15)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- w0_valid  in  1  write request 0 (ALU writeback)
- w0_addr  in  PW  write 0 target register
- w0_data  in  DW  write 0 data
- w0_ready  out  1  write 0 accepted this cycle
- w1_valid / w1_addr / w1_data / w1_ready  same as w0, requester 1 (load return)
- ra_valid  in  1  port-A read request
- ra_addr  in  PW  port-A read address
- ra_ready  out  1  ra_data is valid for ra_addr this cycle
- ra_data  out  DW  port-A read data
- rb_addr  in  PW  port-B read address (never stalled)
- rb_data  out  DW  port-B read data
- rf_wr_en  out  1  to register file write enable
- rf_addrA  out  PW  to register file port-A address (also the write address)
- rf_addrB  out  PW  to register file port-B address
- rf_dat_in  out  DW  to register file write data
- rf_datA  in  DW  from register file port A
- rf_datB  in  DW  from register file port B

## Operation
- State: rr_pref (1 bit, preferred writer) and streak (4 bits).
- Grant is combinational from the valid inputs and the registered state:
  - If streak == STREAK and ra_valid: no writer is granted, rf_addrA = ra_addr, ra_ready = 1.
  - Otherwise, if only one writer is valid, that writer is granted. If both are valid, the writer matching rr_pref is granted.
  - If a writer k is granted: wk_ready = 1, rf_wr_en = 1, rf_addrA = wk_addr, rf_dat_in = wk_data. ra_ready = ra_valid & (ra_addr == wk_addr); the read returns the pre-write value.
  - If no writer is granted: rf_wr_en = 0, rf_addrA = ra_addr, ra_ready = ra_valid.
- rf_addrB = rb_addr. rb_data = rf_datB. ra_data = rf_datA.
- rr_pref update: after a grant to writer k, rr_pref = ~k. Otherwise it holds.
- streak update:
  - Increments when ra_valid & ~ra_ready.
  - Clears to 0 when ra_valid & ra_ready, or when ra_valid = 0.
  - Saturates at STREAK.
- Requesters must hold valid/addr/data stable until they see ready. Dropping valid without ready is illegal.

## Timing
- Reset: rr_pref = 0 (w0 preferred), streak = 0. While reset is high, w0_ready = w1_ready = ra_ready = rf_wr_en = 0.
- Write latency: a handshake at edge N updates the register at edge N. The new value is visible on ra_data/rb_data in cycle N+1.
- Read latency: zero cycles, combinational, when ready.
- A write is never delayed more than 1 cycle by the other writer while both are continuously valid.
- Worst case, a port-A read completes within STREAK+1 cycles of ra_valid rising.
- When streak forces a read cycle, both writers see ready = 0 and retry the next cycle. rr_pref is unchanged.
- Reset asserted mid-operation clears state immediately. No write occurs at an edge where reset is high.

## Configuration
- RF_PERF_CNT_EN defined:
  - Adds output stall_cnt (16 bits), reset to 0.
  - It increments by 1 each cycle in which any of w0, w1, ra is valid and not ready.
  - It saturates at 16'hFFFF.
- RF_PERF_CNT_EN undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Test plan
- Single write: w0 writes reg 2 = 8'hA5. Expect w0_ready = 1, rf_wr_en = 1, rf_addrA = 2; next cycle, rb_addr = 2 gives rb_data = 8'hA5.
- Both writers valid continuously after reset (w0→r1 = 8'h11, w1→r3 = 8'h33, then new data each grant). Expect grants to alternate w0, w1, w0, …
- ra_valid (addr 0) with both writers continuously valid, STREAK = 3. Expect ra_ready low 3 cycles, then high on the 4th with rf_wr_en = 0, and streak back at 0 next cycle.
- Same-address read during a write: w1 writes r1 = 8'h77 (old 8'h11) while ra_addr = 1. Expect ra_ready = 1 and ra_data = 8'h11 that cycle, 8'h77 the next.
- Reset pulse asserted mid-stream while w0 is valid. Expect readys and rf_wr_en = 0 during reset, the target register unchanged, and rr_pref = 0 after release.
- With RF_PERF_CNT_EN defined: 3 stalled-read cycles plus 2 stalled-write cycles give stall_cnt = 5 (each cycle counted once).
